// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a single-entry holding register.
// The rx pin is double-flopped into the clock domain. A small FSM finds the
// start bit, samples mid-bit, and shifts in eight data bits LSB first.
// Good bytes go to a valid/ready holding register. Framing and overrun errors
// are reported as one-cycle pulses.
module uart_rx #(
  parameter int clks_per_bit = 433  // bit period minus one; minimum 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int P  = clks_per_bit + 1;
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit);
  localparam logic [CW-1:0] CNT_HALF = CW'(clks_per_bit / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_good;
  logic          w_ferr;

  // Two-flop synchroniser on the asynchronous rx pin; idles high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (r_s2 gets the old r_s1).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
    end
  end

  // Receiver FSM state, bit counter, bit index and shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: start-bit qualification, mid-bit sampling, stop check.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_s2) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          // A start bit that has gone high again by mid-bit was a glitch.
          w_state_nxt = r_s2 ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_shift_nxt = {r_s2, r_shift[7:1]};
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_s2) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        // Wait for the line to return high so a held-low line cannot retrigger.
        if (r_s2) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding register with valid/ready handshake and registered error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      overrun   <= 1'b0;
      if (w_good) begin
        // A drain in the same cycle frees the slot, so the load is lossless.
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames for uart_rx, checked by a
// scoreboard. The stimulus queues frame completions. A reference model turns
// each completion into an expected output event. A monitor pops that event
// when the DUT presents an output.
module tb_uart_rx;

  localparam int CPB = 7;
  localparam int P   = CPB + 1;
  localparam int H   = CPB / 2;
  localparam int LAT = 3 + H + 9 * P;  // t0 to output edge: 78

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clock = ~clock;

  uart_rx #(.clks_per_bit(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         good;
  } frame_t;

  typedef enum int {EV_BYTE, EV_FERR, EV_OVR} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  frame_t     frame_q[$];
  ev_t        ev_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         mdl_xfer;
  bit         mdl_loaded;
  frame_t     mdl_f;
  bit         prev_valid = 1'b0;
  bit         prev_xfer = 1'b0;
  bit         new_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model. Per clock edge, it tracks whether the one-entry holding
  // register is full and resolves each frame completion into an output event.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      frame_q.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else begin
      mdl_xfer   = m_valid && rx_ready;
      mdl_loaded = 1'b0;
      if (frame_q.size() > 0 && frame_q[0].cyc == cyc) begin
        mdl_f = frame_q.pop_front();
        if (!mdl_f.good) begin
          ev_q.push_back('{EV_FERR, 8'h00, cyc});
        end else if (!m_valid || mdl_xfer) begin
          m_data     = mdl_f.data;
          mdl_loaded = 1'b1;
          ev_q.push_back('{EV_BYTE, mdl_f.data, cyc});
        end else begin
          ev_q.push_back('{EV_OVR, mdl_f.data, cyc});
        end
      end
      if (mdl_loaded) m_valid = 1'b1;
      else if (mdl_xfer) m_valid = 1'b0;
    end
  end

  task automatic take_event(input ev_kind_t k, input logic [7:0] d, input string nm);
    ev_t e;
    if (ev_q.size() == 0) begin
      check({nm, "_unexpected"}, ev_q.size(), 1);
      return;
    end
    e = ev_q.pop_front();
    check({nm, "_kind"}, k, e.kind);
    check({nm, "_cycle"}, cyc, e.cyc);
    if (k == EV_BYTE) check({nm, "_data"}, d, e.data);
  endtask

  // Monitor. It samples on the falling edge, pops the scoreboard whenever
  // the DUT presents a new byte or an error pulse, and checks the handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      new_byte = rx_valid && (!prev_valid || prev_xfer);
      check("rx_valid", rx_valid, m_valid);
      if (m_valid) check("rx_data_held", rx_data, m_data);
      if (frame_err === 1'b1) take_event(EV_FERR, 8'h00, "frame_err");
      if (overrun === 1'b1) take_event(EV_OVR, 8'h00, "overrun");
      if (new_byte) take_event(EV_BYTE, rx_data, "byte");
      if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, ev_q[0].cyc);
        void'(ev_q.pop_front());
      end
      prev_valid = rx_valid;
      prev_xfer  = rx_valid && rx_ready;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Sends one frame starting at the next edge (t0). ready_mode: 0 = leave
  // rx_ready alone, 1 = pulse it only on the completion edge, 2 = random.
  // If abort_bit >= 0, reset is pulsed during that data bit and nothing is queued.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int ready_mode, input int abort_bit);
    logic [9:0] bits;
    int t0;
    int tc;
    bits = {stop_ok, b, 1'b0};
    t0   = cyc + 1;
    tc   = t0 + LAT;
    if (abort_bit < 0) frame_q.push_back('{tc, b, stop_ok});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < P; c++) begin
        if (ready_mode == 1) rx_ready = (cyc + 1 == tc);
        else if (ready_mode == 2) rx_ready = 1'($urandom_range(0, 1));
        if (abort_bit >= 0 && i == abort_bit + 1 && c == 3) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          rx    = 1'b1;
          return;
        end
        step();
      end
    end
    if (ready_mode == 1) rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rgood;

    reset = 1'b1;
    step();
    mon_en = 1'b1;
    idle(3);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    idle(5);

    // Single byte, consumer always ready: valid for exactly one cycle.
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 0, -1);
    idle(4);

    // Glitch: two low cycles, then the next frame starts at t0+6.
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(4);
    send_frame(8'h3C, 1'b1, 0, -1);
    idle(4);

    // Framing error with the line held low, then recovery.
    send_frame(8'hFF, 1'b0, 0, -1);
    idle(32);
    rx = 1'b1;
    idle(4);
    send_frame(8'h01, 1'b1, 0, -1);
    idle(4);

    // Overrun: two back-to-back frames while the consumer is stalled.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(5);
    check("ovr_still_valid", rx_valid, 1'b1);
    check("ovr_kept_first", rx_data, 8'h11);
    rx_ready = 1'b1;
    step();
    check("ovr_drained", rx_valid, 1'b0);
    idle(3);

    // Simultaneous drain and load on the completion edge of 0x66.
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1, 0, -1);
    idle(3);
    send_frame(8'h66, 1'b1, 1, -1);
    idle(2);
    check("swap_valid", rx_valid, 1'b1);
    check("swap_data", rx_data, 8'h66);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    idle(3);

    // Reset during data bit 4 with a byte already pending.
    send_frame(8'h5A, 1'b1, 0, -1);
    idle(3);
    send_frame(8'hC3, 1'b1, 0, 4);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    idle(90);
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1, 0, -1);
    idle(4);

    // Random bytes, random stop-bit errors and random consumer back-pressure.
    repeat (24) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 5) != 0);
      send_frame(rb, rgood, 2, -1);
      rx = 1'b1;
      idle($urandom_range(3, 10));
    end

    rx_ready = 1'b1;
    idle(20);
    check("events_outstanding", ev_q.size(), 0);
    check("frames_outstanding", frame_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
